// File: rtl/w0rm_peripheral_bus_router.sv
// w0rm_peripheral_bus_router
// Request side of the peripheral bus extender: takes one core request at a time,
// decodes it into one of two peripheral windows, strobes that port for one cycle,
// then waits for the merged response (or a timeout) and returns a one-cycle
// response pulse to the core. Decode misses and bad ops are answered immediately
// with an error pulse.
module w0rm_peripheral_bus_router #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           PORT_ADDR_BITS = 8,
   parameter logic [ADDR_WIDTH-1:0] PORT0_BASE     = 32'h8000_0000,
   parameter logic [ADDR_WIDTH-1:0] PORT1_BASE     = 32'h8000_0100,
   parameter int unsigned           TIMEOUT        = 16
) (
   input  logic                  bus_clock,
   input  logic                  bus_reset,
   // core request / response
   input  logic                  mem_valid_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic                  mem_ready_o,
   output logic                  mem_valid_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_error_o,
   // peripheral port 0
   output logic                  port0_valid_o,
   output logic                  port0_read_o,
   output logic                  port0_write_o,
   output logic [ADDR_WIDTH-1:0] port0_addr_o,
   output logic [DATA_WIDTH-1:0] port0_data_o,
   // peripheral port 1
   output logic                  port1_valid_o,
   output logic                  port1_read_o,
   output logic                  port1_write_o,
   output logic [ADDR_WIDTH-1:0] port1_addr_o,
   output logic [DATA_WIDTH-1:0] port1_data_o,
   // merged peripheral response
   input  logic                  bus_valid_i,
   input  logic [DATA_WIDTH-1:0] bus_data_i
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   // A zero TIMEOUT still needs a one-bit timer so the declaration stays legal.
   localparam int unsigned           TIMER_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit                    TIMEOUT_EN = (TIMEOUT != 0);
   localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] PORT0_TAG  = PORT0_BASE >> PORT_ADDR_BITS;
   localparam logic [ADDR_WIDTH-1:0] PORT1_TAG  = PORT1_BASE >> PORT_ADDR_BITS;

   logic [0:0]         state;
   logic [TIMER_W-1:0] timer;
   logic               is_read;
   logic               hit0;
   logic               hit1;
   logic               op_ok;
   logic               route;
   logic               timed_out;

   // Address decode and op check for the request currently on the core bus.
   always_comb begin
      hit0      = (mem_addr_i >> PORT_ADDR_BITS) == PORT0_TAG;
      hit1      = (mem_addr_i >> PORT_ADDR_BITS) == PORT1_TAG;
      op_ok     = mem_read_i ^ mem_write_i;
      route     = op_ok && (hit0 || hit1);
      timed_out = TIMEOUT_EN && (timer == TIMER_LAST);
   end

   assign mem_ready_o = (state == IDLE);

   // Port-side registers: strobe for one cycle, address/data/op held until next hit.
   always_ff @(posedge bus_clock) begin
      if (bus_reset) begin
         port0_valid_o <= 1'b0;
         port0_read_o  <= 1'b0;
         port0_write_o <= 1'b0;
         port0_addr_o  <= '0;
         port0_data_o  <= '0;
         port1_valid_o <= 1'b0;
         port1_read_o  <= 1'b0;
         port1_write_o <= 1'b0;
         port1_addr_o  <= '0;
         port1_data_o  <= '0;
      end else begin
         port0_valid_o <= 1'b0;
         port1_valid_o <= 1'b0;
         if (state == IDLE && mem_valid_i && route) begin
            // port0 takes priority when both windows decode
            if (hit0) begin
               port0_valid_o <= 1'b1;
               port0_read_o  <= mem_read_i;
               port0_write_o <= mem_write_i;
               port0_addr_o  <= mem_addr_i;
               port0_data_o  <= mem_data_i;
            end else begin
               port1_valid_o <= 1'b1;
               port1_read_o  <= mem_read_i;
               port1_write_o <= mem_write_i;
               port1_addr_o  <= mem_addr_i;
               port1_data_o  <= mem_data_i;
            end
         end
      end
   end

   // Control FSM: accept/decode in IDLE, wait for response or timeout in WAIT.
   always_ff @(posedge bus_clock) begin
      if (bus_reset) begin
         state       <= IDLE;
         timer       <= '0;
         is_read     <= 1'b0;
         mem_valid_o <= 1'b0;
         mem_error_o <= 1'b0;
         mem_data_o  <= '0;
      end else begin
         mem_valid_o <= 1'b0;
         mem_error_o <= 1'b0;
         case (state)
            IDLE: begin
               // bus_valid_i here is stale and deliberately ignored
               if (mem_valid_i) begin
                  if (route) begin
                     is_read <= mem_read_i;
                     timer   <= '0;
                     state   <= WAIT;
                  end else begin
                     mem_valid_o <= 1'b1;
                     mem_error_o <= 1'b1;
                     mem_data_o  <= '0;
                  end
               end
            end
            WAIT: begin
               // a response arriving on the timeout cycle still wins
               if (bus_valid_i) begin
                  mem_valid_o <= 1'b1;
                  mem_data_o  <= is_read ? bus_data_i : '0;
                  state       <= IDLE;
               end else begin
                  if (timed_out) begin
                     mem_valid_o <= 1'b1;
                     mem_error_o <= 1'b1;
                     mem_data_o  <= '0;
                     state       <= IDLE;
                  end
                  if (timer != '1) begin
                     timer <= timer + TIMER_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w0rm_peripheral_bus_router.sv
// Self-checking bench for w0rm_peripheral_bus_router: directed scenarios plus
// randomized transactions checked against a transaction-level reference model.
module tb_w0rm_peripheral_bus_router;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned PB = 8;
   localparam logic [31:0] P0 = 32'h8000_0000;
   localparam logic [31:0] P1 = 32'h8000_0100;
   localparam int          TO = 16;

   logic          bus_clock = 1'b0;
   logic          bus_reset = 1'b1;
   logic          mem_valid_i = 1'b0;
   logic          mem_read_i = 1'b0;
   logic          mem_write_i = 1'b0;
   logic [AW-1:0] mem_addr_i = '0;
   logic [DW-1:0] mem_data_i = '0;
   logic          mem_ready_o;
   logic          mem_valid_o;
   logic [DW-1:0] mem_data_o;
   logic          mem_error_o;
   logic          port0_valid_o, port0_read_o, port0_write_o;
   logic [AW-1:0] port0_addr_o;
   logic [DW-1:0] port0_data_o;
   logic          port1_valid_o, port1_read_o, port1_write_o;
   logic [AW-1:0] port1_addr_o;
   logic [DW-1:0] port1_data_o;
   logic          bus_valid_i = 1'b0;
   logic [DW-1:0] bus_data_i = '0;

   int checks = 0;
   int errors = 0;

   w0rm_peripheral_bus_router #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORT_ADDR_BITS(PB),
      .PORT0_BASE(P0), .PORT1_BASE(P1), .TIMEOUT(TO)
   ) dut (
      .bus_clock(bus_clock), .bus_reset(bus_reset),
      .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .mem_ready_o(mem_ready_o), .mem_valid_o(mem_valid_o),
      .mem_data_o(mem_data_o), .mem_error_o(mem_error_o),
      .port0_valid_o(port0_valid_o), .port0_read_o(port0_read_o), .port0_write_o(port0_write_o),
      .port0_addr_o(port0_addr_o), .port0_data_o(port0_data_o),
      .port1_valid_o(port1_valid_o), .port1_read_o(port1_read_o), .port1_write_o(port1_write_o),
      .port1_addr_o(port1_addr_o), .port1_data_o(port1_data_o),
      .bus_valid_i(bus_valid_i), .bus_data_i(bus_data_i)
   );

   always #5 bus_clock = ~bus_clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one cycle; outputs are sampled 1ns after the rising edge
   task automatic step();
      @(posedge bus_clock);
      #1;
   endtask

   task automatic idle_cycle(input logic stale);
      mem_valid_i = 1'b0;
      bus_valid_i = stale;
      bus_data_i  = $urandom;
      step();
      bus_valid_i = 1'b0;
      chk("idle_no_resp", {63'd0, mem_valid_o}, 64'd0);
      chk("idle_no_strobe", {62'd0, port0_valid_o, port1_valid_o}, 64'd0);
      chk("idle_ready", {63'd0, mem_ready_o}, 64'd1);
   endtask

   // One full transaction. delay = WAIT cycle index (0 = strobe cycle) at which
   // bus_valid_i is raised, or -1 for never.
   task automatic do_txn(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
      logic h0, h1, ok, terr;
      logic [31:0] bd;
      int kr;
      h0 = (addr >> PB) == (P0 >> PB);
      h1 = !h0 && ((addr >> PB) == (P1 >> PB));
      ok = (rd != wr);
      chk("ready_before", {63'd0, mem_ready_o}, 64'd1);
      mem_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
      mem_addr_i = addr; mem_data_i = wdata;
      step();
      mem_valid_i = 1'b0; mem_read_i = $urandom; mem_write_i = $urandom;
      mem_addr_i = $urandom; mem_data_i = $urandom;
      if (!ok || !(h0 || h1)) begin
         chk("err_valid", {63'd0, mem_valid_o}, 64'd1);
         chk("err_flag", {63'd0, mem_error_o}, 64'd1);
         chk("err_data", {32'd0, mem_data_o}, 64'd0);
         chk("err_no_strobe", {62'd0, port0_valid_o, port1_valid_o}, 64'd0);
         chk("err_ready", {63'd0, mem_ready_o}, 64'd1);
         return;
      end
      chk("strobe", {62'd0, port0_valid_o, port1_valid_o}, {62'd0, h0, h1});
      if (h0) begin
         chk("p0_addr", {32'd0, port0_addr_o}, {32'd0, addr});
         chk("p0_op", {62'd0, port0_read_o, port0_write_o}, {62'd0, rd, wr});
         chk("p0_data", {32'd0, port0_data_o}, {32'd0, wdata});
      end else begin
         chk("p1_addr", {32'd0, port1_addr_o}, {32'd0, addr});
         chk("p1_op", {62'd0, port1_read_o, port1_write_o}, {62'd0, rd, wr});
         chk("p1_data", {32'd0, port1_data_o}, {32'd0, wdata});
      end
      chk("ready_wait", {63'd0, mem_ready_o}, 64'd0);
      if (delay >= 0 && delay < TO) begin kr = delay; terr = 1'b0; end
      else begin kr = TO - 1; terr = 1'b1; end
      bd = '0;
      for (int k = 0; k <= kr; k++) begin
         bus_valid_i = (k == delay);
         bus_data_i  = (k == delay) ? rdata : $urandom;
         if (k == delay) bd = rdata;
         step();
         bus_valid_i = 1'b0;
         if (k < kr) begin
            chk("wait_no_resp", {63'd0, mem_valid_o}, 64'd0);
            chk("wait_no_strobe", {62'd0, port0_valid_o, port1_valid_o}, 64'd0);
         end
      end
      chk("resp_valid", {63'd0, mem_valid_o}, 64'd1);
      chk("resp_error", {63'd0, mem_error_o}, {63'd0, terr});
      chk("resp_data", {32'd0, mem_data_o}, (terr || !rd) ? 64'd0 : {32'd0, bd});
      chk("resp_ready", {63'd0, mem_ready_o}, 64'd1);
   endtask

   initial begin
      logic [31:0] a;
      logic rd, wr;
      int sel, dly;

      // reset state
      step(); step();
      bus_reset = 1'b0;
      chk("rst_ready", {63'd0, mem_ready_o}, 64'd1);
      chk("rst_valids", {60'd0, mem_valid_o, mem_error_o, port0_valid_o, port1_valid_o}, 64'd0);
      chk("rst_p0", {port0_addr_o, port0_data_o}, 64'd0);
      chk("rst_p1", {port1_addr_o, port1_data_o}, 64'd0);
      chk("rst_data", {32'd0, mem_data_o}, 64'd0);

      // directed scenarios
      do_txn(32'h8000_0004, 1'b1, 1'b0, 32'h0, 2, 32'hDEAD_BEEF);
      do_txn(32'h8000_0110, 1'b0, 1'b1, 32'h55, 1, 32'h1234_5678);
      do_txn(32'h0000_1000, 1'b1, 1'b0, 32'h0, 0, 32'h0);
      do_txn(32'h0000_2000, 1'b0, 1'b1, 32'h0, 0, 32'h0);
      do_txn(32'h8000_0008, 1'b1, 1'b0, 32'h0, -1, 32'h0);
      do_txn(32'h8000_000C, 1'b1, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D);
      do_txn(32'h8000_0010, 1'b1, 1'b1, 32'h0, 0, 32'h0);
      do_txn(32'h8000_0014, 1'b0, 1'b0, 32'h0, 0, 32'h0);
      idle_cycle(1'b1);
      do_txn(32'h8000_0018, 1'b1, 1'b0, 32'h0, 0, 32'hA5A5_5A5A);

      // request held off during WAIT is accepted once the router returns to IDLE
      mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
      mem_addr_i = 32'h8000_0020; mem_data_i = 32'h0;
      step();
      chk("hold_strobe0", {63'd0, port0_valid_o}, 64'd1);
      mem_addr_i = 32'h8000_01F0; mem_read_i = 1'b0; mem_write_i = 1'b1; mem_data_i = 32'h77;
      step();
      chk("hold_ready", {63'd0, mem_ready_o}, 64'd0);
      chk("hold_no_p1", {63'd0, port1_valid_o}, 64'd0);
      bus_valid_i = 1'b1; bus_data_i = 32'h1111_2222;
      step();
      bus_valid_i = 1'b0;
      chk("hold_resp", {32'd0, mem_data_o}, 64'h1111_2222);
      chk("hold_resp_v", {63'd0, mem_valid_o}, 64'd1);
      step();
      mem_valid_i = 1'b0;
      chk("hold_p1_strobe", {63'd0, port1_valid_o}, 64'd1);
      chk("hold_p1_addr", {32'd0, port1_addr_o}, 64'h8000_01F0);
      chk("hold_p1_data", {32'd0, port1_data_o}, 64'h77);
      bus_valid_i = 1'b1;
      step();
      bus_valid_i = 1'b0;
      chk("hold_p1_resp", {63'd0, mem_valid_o}, 64'd1);
      chk("hold_p1_wdata", {32'd0, mem_data_o}, 64'd0);

      // reset mid-WAIT aborts the transaction
      mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
      mem_addr_i = 32'h8000_0030;
      step();
      chk("abort_strobe", {63'd0, port0_valid_o}, 64'd1);
      step();
      mem_valid_i = 1'b0;
      bus_reset = 1'b1;
      step();
      bus_reset = 1'b0;
      chk("abort_ready", {63'd0, mem_ready_o}, 64'd1);
      chk("abort_valids", {60'd0, mem_valid_o, mem_error_o, port0_valid_o, port1_valid_o}, 64'd0);
      chk("abort_p0", {port0_addr_o, port0_data_o}, 64'd0);
      chk("abort_p1", {port1_addr_o, port1_data_o}, 64'd0);
      chk("abort_data", {32'd0, mem_data_o}, 64'd0);
      idle_cycle(1'b1);
      do_txn(32'h8000_0104, 1'b1, 1'b0, 32'h0, 3, 32'h0BAD_F00D);

      // randomized transactions with stale responses sprinkled between them
      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 2);
         a = $urandom;
         if (sel == 0) a = P0 | {24'd0, a[7:0]};
         else if (sel == 1) a = P1 | {24'd0, a[7:0]};
         case ($urandom_range(0, 7))
            0, 1, 2: begin rd = 1'b1; wr = 1'b0; end
            3, 4, 5: begin rd = 1'b0; wr = 1'b1; end
            6:       begin rd = 1'b1; wr = 1'b1; end
            default: begin rd = 1'b0; wr = 1'b0; end
         endcase
         dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
         do_txn(a, rd, wr, $urandom, dly, $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
